// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and constants for the two-port memory arbiter
package mem_arbiter_pkg;

  // Sequencer states: IDLE arbitrates, ISSUE drives the memory strobe,
  // RESP captures registered read data, ERR reports a rejected address.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

  typedef enum logic {
    PORT_FETCH = 1'b0,
    PORT_DATA  = 1'b1
  } port_t;

  localparam int WORD_BYTES        = 4;
  localparam int MEM_BYTES_DEFAULT = 64;

endpackage

// File: rtl/mem_rr_arb2.sv
// rtl/mem_rr_arb2.sv - combinational two-requester round-robin picker
//   i_req_fetch   : fetch port eligible this cycle
//   i_req_data    : data port eligible this cycle
//   i_last_grant  : port granted most recently (port_t encoding)
//   o_grant_valid : at least one requester eligible
//   o_grant_id    : chosen port (port_t encoding)
module mem_rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic i_req_fetch,
  input  logic i_req_data,
  input  logic i_last_grant,
  output logic o_grant_valid,
  output logic o_grant_id
);

  always_comb begin
    o_grant_valid = i_req_fetch | i_req_data;
    o_grant_id    = PORT_FETCH;
    if (i_req_fetch && i_req_data) begin
      // Contention: the port that did not win last time goes next.
      o_grant_id = (i_last_grant == PORT_FETCH) ? PORT_DATA : PORT_FETCH;
    end else if (i_req_data) begin
      o_grant_id = PORT_DATA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter and sequencer for a single-port big-endian memory
//   clk, reset                       : clock, synchronous active-high reset
//   i_req/i_addr                     : fetch request, held until i_done
//   i_done/i_err/i_rdata             : fetch completion pulse, error flag, fetched word
//   d_req/d_we/d_addr/d_wdata        : data request, held until d_done
//   d_done/d_err/d_rdata             : data completion pulse, error flag, load word
//   mem_address/mem_write_data       : memory address and store data
//   mem_write/mem_read/mem_read_data : memory strobes and registered read data
//   busy                             : sequencer not idle
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEFAULT,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic              i_err,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic              d_err,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES - WORD_BYTES);

  state_t            r_state;
  port_t             r_last_grant;
  port_t             r_port;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_i_done;
  logic              r_i_err;
  logic [DATA_W-1:0] r_i_rdata;
  logic              r_d_done;
  logic              r_d_err;
  logic [DATA_W-1:0] r_d_rdata;

  logic              w_i_elig;
  logic              w_d_elig;
  logic              w_grant_valid;
  logic              w_grant_id;
  logic              w_sel_data;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_sel_bad;

  // A requester still shows req in its own done cycle; masking it there
  // lets the other port take the memory without a bubble.
  assign w_i_elig = i_req & ~r_i_done;
  assign w_d_elig = d_req & ~r_d_done;

  mem_rr_arb2 u_rr_arb2 (
    .i_req_fetch   (w_i_elig),
    .i_req_data    (w_d_elig),
    .i_last_grant  (r_last_grant),
    .o_grant_valid (w_grant_valid),
    .o_grant_id    (w_grant_id)
  );

  assign w_sel_data  = (w_grant_id == PORT_DATA);
  assign w_sel_we    = w_sel_data ? d_we : 1'b0;
  assign w_sel_addr  = w_sel_data ? d_addr : i_addr;
  assign w_sel_wdata = w_sel_data ? d_wdata : '0;
  assign w_sel_bad   = (w_sel_addr[1:0] != 2'b00) || (w_sel_addr > LAST_WORD);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_last_grant <= PORT_FETCH;
      r_port       <= PORT_FETCH;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_i_done     <= 1'b0;
      r_i_err      <= 1'b0;
      r_i_rdata    <= '0;
      r_d_done     <= 1'b0;
      r_d_err      <= 1'b0;
      r_d_rdata    <= '0;
    end else begin
      r_i_done <= 1'b0;
      r_i_err  <= 1'b0;
      r_d_done <= 1'b0;
      r_d_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant_valid) begin
            r_port       <= port_t'(w_grant_id);
            r_last_grant <= port_t'(w_grant_id);
            r_we         <= w_sel_we;
            r_addr       <= w_sel_addr;
            r_wdata      <= w_sel_wdata;
            r_state      <= w_sel_bad ? ST_ERR : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Only the data port can hold a store, so a store completes there.
          if (r_we) begin
            r_d_done <= 1'b1;
            r_state  <= ST_IDLE;
          end else begin
            r_state  <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (r_port == PORT_DATA) begin
            r_d_rdata <= mem_read_data;
            r_d_done  <= 1'b1;
          end else begin
            r_i_rdata <= mem_read_data;
            r_i_done  <= 1'b1;
          end
          r_state <= ST_IDLE;
        end
        ST_ERR: begin
          if (r_port == PORT_DATA) begin
            r_d_done <= 1'b1;
            r_d_err  <= 1'b1;
          end else begin
            r_i_done <= 1'b1;
            r_i_err  <= 1'b1;
          end
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Memory interface decodes from state only; idle and error cycles drive zeros.
  assign busy           = (r_state != ST_IDLE);
  assign mem_read       = (r_state == ST_ISSUE) && !r_we;
  assign mem_write      = (r_state == ST_ISSUE) && r_we;
  assign mem_address    = ((r_state == ST_ISSUE) || (r_state == ST_RESP)) ? r_addr : '0;
  assign mem_write_data = mem_write ? r_wdata : '0;

  assign i_done  = r_i_done;
  assign i_err   = r_i_err;
  assign i_rdata = r_i_rdata;
  assign d_done  = r_d_done;
  assign d_err   = r_d_err;
  assign d_rdata = r_d_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_done;
  logic        i_err;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_done;
  logic        d_err;
  logic [31:0] d_rdata;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_read_data;
  logic        busy;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_BYTES(64), .ADDR_W(32), .DATA_W(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_req          (i_req),
    .i_addr         (i_addr),
    .i_done         (i_done),
    .i_err          (i_err),
    .i_rdata        (i_rdata),
    .d_req          (d_req),
    .d_we           (d_we),
    .d_addr         (d_addr),
    .d_wdata        (d_wdata),
    .d_done         (d_done),
    .d_err          (d_err),
    .d_rdata        (d_rdata),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_write      (mem_write),
    .mem_read       (mem_read),
    .mem_read_data  (mem_read_data),
    .busy           (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory environment: big-endian bytes, registered read, posedge write.
  logic [7:0] env_mem [64];
  bit env_ready = 1'b0;
  always @(posedge clk) begin
    if (!env_ready) begin
      for (int i = 0; i < 64; i++) env_mem[i] <= 8'(i);
      env_mem[8]  <= 8'h12; env_mem[9]  <= 8'h34; env_mem[10] <= 8'h56; env_mem[11] <= 8'h78;
      env_mem[60] <= 8'hA1; env_mem[61] <= 8'hB2; env_mem[62] <= 8'hC3; env_mem[63] <= 8'hD4;
      env_ready <= 1'b1;
    end else begin
      if (mem_write) begin
        env_mem[mem_address[5:0]]        <= mem_write_data[31:24];
        env_mem[mem_address[5:0] + 6'd1] <= mem_write_data[23:16];
        env_mem[mem_address[5:0] + 6'd2] <= mem_write_data[15:8];
        env_mem[mem_address[5:0] + 6'd3] <= mem_write_data[7:0];
      end
      if (mem_read)
        mem_read_data <= {env_mem[mem_address[5:0]], env_mem[mem_address[5:0] + 6'd1],
                          env_mem[mem_address[5:0] + 6'd2], env_mem[mem_address[5:0] + 6'd3]};
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit mon_en = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (!busy) chk("idle_mem_quiet", 32'({mem_read, mem_write, |mem_address, |mem_write_data}), 32'd0);
      if (i_done && d_done) chk("single_done", 32'(i_done & d_done), 32'd0);
    end
  end

  // Reference model: byte memory plus last-returned word per port.
  logic [7:0]  model_mem [64];
  logic [31:0] m_i_rdata;
  logic [31:0] m_d_rdata;

  function automatic logic [31:0] model_word(input int a);
    return {model_mem[a], model_mem[a+1], model_mem[a+2], model_mem[a+3]};
  endfunction

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  req_t fq[$];
  req_t dq[$];
  int   done_port[$];
  int   done_cyc[$];
  int   max_gap;

  function automatic req_t rand_req(input bit is_d);
    req_t r;
    int sel;
    sel     = int'($urandom_range(0, 9));
    r.we    = is_d ? 1'($urandom_range(0, 1)) : 1'b0;
    r.wdata = $urandom;
    if (sel < 7)       r.addr = 32'($urandom_range(0, 15)) * 4;
    else if (sel == 7) r.addr = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
    else if (sel == 8) r.addr = 32'h40 + 32'($urandom_range(0, 15)) * 4;
    else               r.addr = $urandom | 32'h100;
    return r;
  endfunction

  task automatic agent(input bit is_d);
    req_t r;
    int gap;
    bit seen;
    bit exp_err;
    bit first;
    int a;
    first = 1'b1;
    while (1) begin
      if (is_d) begin
        if (dq.size() == 0) break;
        r = dq.pop_front();
      end else begin
        if (fq.size() == 0) break;
        r = fq.pop_front();
      end
      gap = first ? 0 : int'($urandom_range(0, max_gap));
      first = 1'b0;
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
      if (is_d) begin d_req = 1'b1; d_we = r.we; d_addr = r.addr; d_wdata = r.wdata; end
      else begin i_req = 1'b1; i_addr = r.addr; end
      seen = 1'b0;
      for (int k = 0; k < 30 && !seen; k++) begin
        @(negedge clk);
        if (is_d ? d_done : i_done) begin
          seen = 1'b1;
          chk("rr_latency_bound", 32'(k <= 6), 32'd1);
          exp_err = (r.addr[1:0] != 2'b00) || (r.addr > 32'd60);
          if (!exp_err) begin
            a = int'(r.addr[5:0]);
            if (r.we) begin
              model_mem[a] = r.wdata[31:24]; model_mem[a+1] = r.wdata[23:16];
              model_mem[a+2] = r.wdata[15:8]; model_mem[a+3] = r.wdata[7:0];
            end else if (is_d) m_d_rdata = model_word(a);
            else m_i_rdata = model_word(a);
          end
          if (is_d) begin
            chk("rand_d_err", 32'(d_err), 32'(exp_err));
            chk("rand_d_rdata", d_rdata, m_d_rdata);
          end else begin
            chk("rand_i_err", 32'(i_err), 32'(exp_err));
            chk("rand_i_rdata", i_rdata, m_i_rdata);
          end
          done_port.push_back(int'(is_d));
          done_cyc.push_back(cyc);
        end
      end
      chk("agent_done_seen", 32'(seen), 32'd1);
      @(posedge clk);
      #1;
      if (is_d) d_req = 1'b0; else i_req = 1'b0;
    end
  endtask

  task automatic txn(input bit is_d, input bit we, input logic [31:0] addr, input logic [31:0] wd,
                     output int lat, output bit err, output int nrd, output int nwr, output bit ok);
    @(posedge clk);
    #1;
    if (is_d) begin d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd; end
    else begin i_req = 1'b1; i_addr = addr; end
    lat = -1; err = 1'b0; nrd = 0; nwr = 0; ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (mem_read) begin nrd++; chk("txn_rd_addr", mem_address, addr); end
      if (mem_write) begin
        nwr++;
        chk("txn_wr_addr", mem_address, addr);
        chk("txn_wr_data", mem_write_data, wd);
      end
      if (is_d ? d_done : i_done) begin
        lat = k;
        err = is_d ? d_err : i_err;
        ok  = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    i_req = 1'b0;
    d_req = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    i_req = 1'b0;
    d_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          e_err;
    int          e_lat;
    logic [31:0] e_rdata;
    int          e_rd;
    int          e_wr;
  } vec_t;

  vec_t vt[12];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, nrd, nwr, start;
    bit err, ok;

    vt[0]  = '{1'b0, 1'b0, 32'h08, 32'h0,        1'b0, 3, 32'h12345678, 1, 0};
    vt[1]  = '{1'b1, 1'b1, 32'h20, 32'hDEADBEEF, 1'b0, 2, 32'h00000000, 0, 1};
    vt[2]  = '{1'b1, 1'b0, 32'h20, 32'h0,        1'b0, 3, 32'hDEADBEEF, 1, 0};
    vt[3]  = '{1'b1, 1'b0, 32'h22, 32'h0,        1'b1, 2, 32'hDEADBEEF, 0, 0};
    vt[4]  = '{1'b0, 1'b0, 32'h3C, 32'h0,        1'b0, 3, 32'hA1B2C3D4, 1, 0};
    vt[5]  = '{1'b0, 1'b0, 32'h40, 32'h0,        1'b1, 2, 32'hA1B2C3D4, 0, 0};
    vt[6]  = '{1'b1, 1'b1, 32'h3C, 32'h0BADF00D, 1'b0, 2, 32'hDEADBEEF, 0, 1};
    vt[7]  = '{1'b0, 1'b0, 32'h3C, 32'h0,        1'b0, 3, 32'h0BADF00D, 1, 0};
    vt[8]  = '{1'b1, 1'b0, 32'hFFFFFFFC, 32'h0,  1'b1, 2, 32'hDEADBEEF, 0, 0};
    vt[9]  = '{1'b1, 1'b1, 32'h01, 32'h55555555, 1'b1, 2, 32'hDEADBEEF, 0, 0};
    vt[10] = '{1'b1, 1'b0, 32'h00, 32'h0,        1'b0, 3, 32'h00010203, 1, 0};
    vt[11] = '{1'b1, 1'b0, 32'h08, 32'h0,        1'b0, 3, 32'h12345678, 1, 0};

    reset = 1'b1; i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_dones", 32'({i_done, d_done, i_err, d_err}), 32'd0);
    chk("rst_strobes", 32'({mem_read, mem_write}), 32'd0);
    chk("rst_i_rdata", i_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 12; i++) begin
      txn(vt[i].is_d, vt[i].we, vt[i].addr, vt[i].wdata, lat, err, nrd, nwr, ok);
      chk($sformatf("v%0d_done", i), 32'(ok), 32'd1);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vt[i].e_lat));
      chk($sformatf("v%0d_err", i), 32'(err), 32'(vt[i].e_err));
      chk($sformatf("v%0d_nrd", i), 32'(nrd), 32'(vt[i].e_rd));
      chk($sformatf("v%0d_nwr", i), 32'(nwr), 32'(vt[i].e_wr));
      chk($sformatf("v%0d_rdata", i), vt[i].is_d ? d_rdata : i_rdata, vt[i].e_rdata);
    end

    // Model picks up the memory contents the table left behind.
    for (int i = 0; i < 64; i++) model_mem[i] = 8'(i);
    {model_mem[8], model_mem[9], model_mem[10], model_mem[11]}   = 32'h12345678;
    {model_mem[32], model_mem[33], model_mem[34], model_mem[35]} = 32'hDEADBEEF;
    {model_mem[60], model_mem[61], model_mem[62], model_mem[63]} = 32'h0BADF00D;

    // Both ports request in the first cycle after reset and keep requesting.
    do_reset();
    m_i_rdata = '0;
    m_d_rdata = '0;
    max_gap = 0;
    for (int i = 0; i < 4; i++) begin
      dq.push_back('{1'b0, 32'(i * 8), 32'h0});
      fq.push_back('{1'b0, 32'(60 - i * 4), 32'h0});
    end
    done_port.delete();
    done_cyc.delete();
    start = cyc;
    fork
      agent(1'b1);
      agent(1'b0);
    join
    chk("b2b_count", 32'(done_port.size()), 32'd8);
    if (done_port.size() == 8) begin
      chk("b2b_first_lat", 32'(done_cyc[0] - start), 32'd3);
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("b2b_order%0d", i), 32'(done_port[i]), 32'((i % 2 == 0) ? 1 : 0));
        if (i > 0) chk($sformatf("b2b_gap%0d", i), 32'(done_cyc[i] - done_cyc[i-1]), 32'd3);
      end
    end

    // Reset lands on the RESP edge of a load: abandoned, no done pulse.
    @(posedge clk);
    #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    @(negedge clk);
    @(negedge clk);
    chk("rstmid_issue_read", 32'(mem_read), 32'd1);
    @(negedge clk);
    chk("rstmid_resp_busy", 32'(busy), 32'd1);
    chk("rstmid_resp_noread", 32'(mem_read), 32'd0);
    reset = 1'b1;
    d_req = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_no_done", 32'(d_done), 32'd0);
    chk("rstmid_d_rdata", d_rdata, 32'd0);
    chk("rstmid_i_rdata", i_rdata, 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("rstmid_quiet", 32'({d_done, i_done, busy}), 32'd0);
    end
    txn(1'b1, 1'b0, 32'h20, 32'h0, lat, err, nrd, nwr, ok);
    chk("rstmid_fresh_done", 32'(ok), 32'd1);
    chk("rstmid_fresh_lat", 32'(lat), 32'd3);
    chk("rstmid_fresh_rdata", d_rdata, 32'hDEADBEEF);

    // Randomized traffic on both ports against the model.
    m_i_rdata = '0;
    m_d_rdata = 32'hDEADBEEF;
    max_gap = 2;
    for (int i = 0; i < 40; i++) begin
      dq.push_back(rand_req(1'b1));
      fq.push_back(rand_req(1'b0));
    end
    done_port.delete();
    done_cyc.delete();
    fork
      agent(1'b1);
      agent(1'b0);
    join
    chk("rand_count", 32'(done_port.size()), 32'd80);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
